// File: rtl/program_counter_stack_module.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// program_counter_stack_module
//
// Program counter with a small return-address stack and a tri-state bus port.
// One operation executes per rising clock edge, priority call > ret > ie > step.
// While oe is high the PC is driven onto the bus, so jumps and calls (which
// would read the bus) are ignored; ret and step still work.
//
// Optional build macro:
//   PC_STACK_FAULT_EN - when defined, call-when-full and ret-when-empty set a
//                       sticky err flag that is cleared only by rst. When
//                       undefined, err is tied to 0 and no fault logic exists.
//
// Parameters:
//   WIDTH - PC and bus width in bits (4..16)
//   DEPTH - return-address stack entries (1..16)
//
// Ports:
//   clk   in     clock, all state updates on the rising edge
//   rst   in     asynchronous active-high reset
//   ie    in     load PC from bus (jump)
//   oe    in     drive PC onto bus
//   step  in     increment PC
//   call  in     push return address (PC+1) and load PC from bus
//   ret   in     pop stack top into PC
//   data  out    current PC (registered)
//   bus   inout  shared system bus
//   level out    number of valid stack entries
//   full  out    level == DEPTH
//   empty out    level == 0
//   err   out    sticky stack-fault flag
// -----------------------------------------------------------------------------
module program_counter_stack_module #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ie,
    input  logic                       oe,
    input  logic                       step,
    input  logic                       call,
    input  logic                       ret,
    output logic [WIDTH-1:0]           data,
    inout  wire  [WIDTH-1:0]           bus,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);

    localparam int LW = $clog2(DEPTH + 1);
    // Stack address width; at least one bit so DEPTH=1 still has an index.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [WIDTH-1:0] data_q, data_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] stack_q [2**AW];
    logic             push;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    pop_idx;
    logic             call_eff;
    logic             ie_eff;

    // The bus follows oe immediately, including during reset (data_q is 0 then).
    assign bus = oe ? data_q : 'z;

    // Bus-reading operations are meaningless while we drive the bus ourselves.
    assign call_eff = call & ~oe;
    assign ie_eff   = ie & ~oe;

    assign full  = (level_q == DEPTH_L);
    assign empty = (level_q == '0);

    // Entries at or above level are never read, so truncating to AW bits is
    // safe: a push only happens below DEPTH, a pop only happens above 0.
    assign push_idx = AW'(level_q);
    assign pop_idx  = AW'(level_q - 1'b1);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        data_d  = data_q;
        level_d = level_q;
        push    = 1'b0;
        if (call_eff) begin
            // The jump happens even when the stack is full; only the push is lost.
            data_d = bus;
            if (!full) begin
                push    = 1'b1;
                level_d = level_q + 1'b1;
            end
        end else if (ret) begin
            if (!empty) begin
                data_d  = stack_q[pop_idx];
                level_d = level_q - 1'b1;
            end
        end else if (ie_eff) begin
            data_d = bus;
        end else if (step) begin
            data_d = data_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, so the order of statements does not matter.
            data_q  <= '0;
            level_q <= '0;
        end else begin
            data_q  <= data_d;
            level_q <= level_d;
        end
    end

    // NOTE: the stack storage has no reset; level alone decides which entries
    // are valid, so clearing the array would only cost flops.
    // A push that coincides with reset is discarded along with the level update.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            stack_q[push_idx] <= data_q + 1'b1;
        end
    end

`ifdef PC_STACK_FAULT_EN
    logic fault;
    logic err_q;

    // Same decode as the datapath: a call that cannot push, or a ret that
    // cannot pop because nothing outranks it.
    assign fault = (call_eff & full) | (~call_eff & ret & empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (fault) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign data  = data_q;
    assign level = level_q;

endmodule

// File: tb/tb_program_counter_stack_module.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_program_counter_stack_module
//
// Directed, table-driven bench for program_counter_stack_module (WIDTH=8,
// DEPTH=4). Each table row is one clock edge of stimulus with the PC, level
// and fault flag expected after that edge. Bus visibility and the
// asynchronous reset are exercised by short hand-written sequences.
// -----------------------------------------------------------------------------
module tb_program_counter_stack_module;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

`ifdef PC_STACK_FAULT_EN
    localparam bit FAULT_BUILD = 1'b1;
`else
    localparam bit FAULT_BUILD = 1'b0;
`endif

    typedef struct packed {
        logic             ie;
        logic             oe;
        logic             step;
        logic             call;
        logic             ret;
        logic [WIDTH-1:0] bus;
        logic [WIDTH-1:0] exp_data;
        logic [LW-1:0]    exp_level;
        logic             exp_ferr;   // err value expected in the fault build
    } vec_t;

    localparam int NVEC = 35;

    logic             clk;
    logic             rst;
    logic             ie;
    logic             oe;
    logic             step;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] data;
    wire  [WIDTH-1:0] bus;
    logic [LW-1:0]    level;
    logic             full;
    logic             empty;
    logic             err;

    logic             tb_drv;
    logic [WIDTH-1:0] tb_bus;

    int checks   = 0;
    int failures = 0;

    vec_t vecs [NVEC];

    assign bus = tb_drv ? tb_bus : 'z;

    program_counter_stack_module #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ie    (ie),
        .oe    (oe),
        .step  (step),
        .call  (call),
        .ret   (ret),
        .data  (data),
        .bus   (bus),
        .level (level),
        .full  (full),
        .empty (empty),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic i_ie, input logic i_oe, input logic i_step,
                                input logic i_call, input logic i_ret,
                                input logic [WIDTH-1:0] i_bus, input logic [WIDTH-1:0] e_data,
                                input logic [LW-1:0] e_level, input logic e_ferr);
        vec_t v;
        v.ie        = i_ie;
        v.oe        = i_oe;
        v.step      = i_step;
        v.call      = i_call;
        v.ret       = i_ret;
        v.bus       = i_bus;
        v.exp_data  = e_data;
        v.exp_level = e_level;
        v.exp_ferr  = e_ferr;
        return v;
    endfunction

    task automatic check_state(input string tag, input logic [WIDTH-1:0] e_data,
                               input logic [LW-1:0] e_level, input logic e_ferr);
        check({tag, ".data"},  16'(data),  16'(e_data));
        check({tag, ".level"}, 16'(level), 16'(e_level));
        check({tag, ".full"},  16'(full),  16'(e_level == LW'(DEPTH)));
        check({tag, ".empty"}, 16'(empty), 16'(e_level == '0));
        check({tag, ".err"},   16'(err),   16'(FAULT_BUILD & e_ferr));
    endtask

    // Drive one row on the falling edge, let the rising edge act, then check.
    task automatic apply_row(input string tag, input vec_t v);
        @(negedge clk);
        ie     = v.ie;
        oe     = v.oe;
        step   = v.step;
        call   = v.call;
        ret    = v.ret;
        tb_drv = ~v.oe;
        tb_bus = v.bus;
        @(posedge clk);
        #1;
        check_state(tag, v.exp_data, v.exp_level, v.exp_ferr);
    endtask

    initial begin
        //               ie oe st ca re  bus    data   lvl ferr
        vecs[0]  = mk(0, 0, 1, 0, 0, 8'h00, 8'h01, 0, 0);  // step
        vecs[1]  = mk(0, 0, 1, 0, 0, 8'h00, 8'h02, 0, 0);  // step
        vecs[2]  = mk(0, 0, 1, 0, 0, 8'h00, 8'h03, 0, 0);  // step
        vecs[3]  = mk(1, 0, 0, 0, 0, 8'hFF, 8'hFF, 0, 0);  // jump to FF
        vecs[4]  = mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0);  // step wraps
        vecs[5]  = mk(1, 0, 0, 0, 0, 8'hFF, 8'hFF, 0, 0);  // jump to FF
        vecs[6]  = mk(0, 0, 0, 1, 0, 8'h40, 8'h40, 1, 0);  // call, return addr wraps to 00
        vecs[7]  = mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0);  // ret -> 00
        vecs[8]  = mk(1, 0, 0, 0, 0, 8'h10, 8'h10, 0, 0);  // jump to 10
        vecs[9]  = mk(0, 0, 0, 1, 0, 8'h20, 8'h20, 1, 0);  // call, push 11
        vecs[10] = mk(1, 0, 0, 0, 0, 8'h22, 8'h22, 1, 0);  // jump to 22
        vecs[11] = mk(0, 0, 0, 1, 0, 8'h30, 8'h30, 2, 0);  // call, push 23
        vecs[12] = mk(0, 0, 0, 0, 1, 8'h00, 8'h23, 1, 0);  // ret
        vecs[13] = mk(0, 0, 0, 0, 1, 8'h00, 8'h11, 0, 0);  // ret
        vecs[14] = mk(1, 0, 0, 0, 0, 8'h05, 8'h05, 0, 0);  // jump to 05
        vecs[15] = mk(1, 0, 1, 1, 1, 8'h80, 8'h80, 1, 0);  // all requests: call wins, push 06
        vecs[16] = mk(0, 0, 0, 0, 1, 8'h00, 8'h06, 0, 0);  // ret shows stack top 06
        vecs[17] = mk(0, 0, 0, 1, 0, 8'h50, 8'h50, 1, 0);  // call at 06, push 07? no: at 06 -> push 07
        vecs[18] = mk(1, 1, 1, 1, 1, 8'h00, 8'h07, 0, 0);  // oe=1: call ignored, ret wins
        vecs[19] = mk(1, 1, 0, 0, 0, 8'h00, 8'h07, 0, 0);  // oe=1: jump ignored
        vecs[20] = mk(0, 1, 1, 0, 0, 8'h00, 8'h08, 0, 0);  // oe=1: step still works
        vecs[21] = mk(0, 0, 0, 0, 0, 8'h00, 8'h08, 0, 0);  // idle hold
        vecs[22] = mk(0, 0, 0, 1, 0, 8'hA0, 8'hA0, 1, 0);  // push 09
        vecs[23] = mk(0, 0, 0, 1, 0, 8'hB0, 8'hB0, 2, 0);  // push A1
        vecs[24] = mk(0, 0, 0, 1, 0, 8'hC0, 8'hC0, 3, 0);  // push B1
        vecs[25] = mk(0, 0, 0, 1, 0, 8'hD0, 8'hD0, 4, 0);  // push C1, full
        vecs[26] = mk(0, 0, 0, 1, 0, 8'hE0, 8'hE0, 4, 1);  // call when full: jump only, fault
        vecs[27] = mk(0, 0, 0, 0, 1, 8'h00, 8'hC1, 3, 1);  // ret
        vecs[28] = mk(0, 0, 0, 0, 1, 8'h00, 8'hB1, 2, 1);
        vecs[29] = mk(0, 0, 0, 0, 1, 8'h00, 8'hA1, 1, 1);
        vecs[30] = mk(0, 0, 0, 0, 1, 8'h00, 8'h09, 0, 1);
        vecs[31] = mk(0, 0, 0, 0, 1, 8'h00, 8'h09, 0, 1);  // ret when empty: hold
        vecs[32] = mk(0, 0, 0, 1, 0, 8'h11, 8'h11, 1, 1);  // build level 3 for reset test
        vecs[33] = mk(0, 0, 0, 1, 0, 8'h22, 8'h22, 2, 1);
        vecs[34] = mk(0, 0, 0, 1, 0, 8'h33, 8'h33, 3, 1);

        rst    = 1'b1;
        ie     = 1'b0;
        oe     = 1'b0;
        step   = 1'b0;
        call   = 1'b0;
        ret    = 1'b0;
        tb_drv = 1'b1;
        tb_bus = '0;
        #1;
        check_state("reset", 8'h00, 0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            apply_row($sformatf("row%0d", i), vecs[i]);
        end

        // Bus visibility with no cycle of latency.
        @(negedge clk);
        step   = 1'b0;
        tb_drv = 1'b0;
        oe     = 1'b1;
        #1;
        check("bus_oe1", 16'(bus), 16'h0003);
        oe     = 1'b0;
        tb_drv = 1'b1;
        tb_bus = 8'hA5;
        #1;
        check("bus_oe0_released", 16'(bus), 16'h00A5);

        for (int i = 3; i < NVEC; i++) begin
            apply_row($sformatf("row%0d", i), vecs[i]);
        end

        // Asynchronous reset mid-cycle with level=3 (and err=1 in the fault build).
        #2;
        rst = 1'b1;
        #1;
        check_state("async_rst", 8'h00, 0, 1'b0);
        tb_drv = 1'b0;
        oe     = 1'b1;
        #1;
        check("bus_in_reset", 16'(bus), 16'h0000);

        // A call held across an edge while in reset is discarded.
        @(negedge clk);
        oe     = 1'b0;
        tb_drv = 1'b1;
        tb_bus = 8'h77;
        call   = 1'b1;
        @(posedge clk);
        #1;
        check_state("call_in_reset", 8'h00, 0, 1'b0);

        // First edge after release executes normally.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_state("call_after_reset", 8'h77, 1, 1'b0);
        apply_row("ret_after_reset", mk(0, 0, 0, 0, 1, 8'h00, 8'h01, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
